// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_CSUM     = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW = 3'd2;
  localparam logic [2:0] ERR_RANGE    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_prog_loader_byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word; word_c/word_done_c include the current byte.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_c,
  output logic        word_done_c
);

  logic [23:0] shift;
  logic [1:0]  cnt;

  assign word_c      = {byte_in, shift};
  assign word_done_c = byte_valid && !clear && (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= 24'd0;
      cnt   <= 2'd0;
    end else if (clear) begin
      shift <= 24'd0;
      cnt   <= 2'd0;
    end else if (byte_valid) begin
      shift <= {byte_in, shift[23:8]};
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Parses framed UART load packets into 32-bit memory writes and holds the CPU in reset while loading.
// Build option: define LOADER_TIMEOUT_EN to abort packets that stall longer than TIMEOUT_CYCLES.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done_pulse,
  output logic              err_pulse,
  output logic [2:0]        err_code
);

  localparam logic [16:0] MEM_WORDS = 17'(2 ** ADDR_W);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t            state, state_d;
  logic [7:0]        csum;
  logic [1:0]        hdr_cnt;
  logic [23:0]       hdr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0]       words_left;

  logic [15:0] hdr_addr_c, hdr_len_c;
  logic [7:0]  csum_next_c;
  logic        range_bad_c, overflow_c, load_c;
  logic [31:0] word_c;
  logic        word_done_c;
  logic        err_set_c, done_set_c, hold_set_c;
  logic [2:0]  err_d_c;
  logic        tmo_hit_c;

  // Header bytes arrive ADDR_LO, ADDR_HI, LEN_LO; LEN_HI is the current byte on completion.
  assign hdr_addr_c  = hdr[15:0];
  assign hdr_len_c   = {rx_byte, hdr[23:16]};
  assign csum_next_c = csum + rx_byte;
  assign range_bad_c = ((17'(hdr_addr_c) + 17'(hdr_len_c)) > MEM_WORDS) ||
                       ((hdr_addr_c >> ADDR_W) != 16'd0);
  assign overflow_c  = word_done_c && wr_valid && !wr_ready;
  assign load_c      = word_done_c && !overflow_c;

  byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (state != DATA),
    .byte_valid  (rx_valid && (state == DATA)),
    .byte_in     (rx_byte),
    .word_c      (word_c),
    .word_done_c (word_done_c)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             active_c;

  assign active_c  = (state == HDR) || (state == DATA) || (state == CSUM);
  assign tmo_hit_c = active_c && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte gap counter, restarted by every received byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   tmo_cnt <= '0;
    else if (rx_valid || !active_c) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    err_set_c  = 1'b0;
    err_d_c    = ERR_NONE;
    done_set_c = 1'b0;
    hold_set_c = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          state_d    = HDR;
          hold_set_c = 1'b1;
        end
      end
      HDR: begin
        if (rx_valid && (hdr_cnt == 2'd3)) begin
          if (range_bad_c) begin
            state_d   = IDLE;
            err_set_c = 1'b1;
            err_d_c   = ERR_RANGE;
          end else if (hdr_len_c == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (overflow_c) begin
          state_d   = IDLE;
          err_set_c = 1'b1;
          err_d_c   = ERR_OVERFLOW;
        end else if (word_done_c && (words_left == 16'd1)) begin
          state_d = CSUM;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (csum_next_c == 8'd0) begin
            state_d = DRAIN;
          end else begin
            state_d   = IDLE;
            err_set_c = 1'b1;
            err_d_c   = ERR_CSUM;
          end
        end
      end
      DRAIN: begin
        if (!wr_valid) begin
          state_d    = IDLE;
          done_set_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmo_hit_c) begin
      state_d   = IDLE;
      err_set_c = 1'b1;
      err_d_c   = ERR_TIMEOUT;
    end
  end

  // Packet datapath: checksum, header capture, word pointer and the write register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum       <= 8'd0;
      hdr_cnt    <= 2'd0;
      hdr        <= 24'd0;
      wr_ptr     <= '0;
      words_left <= 16'd0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 32'd0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      if (state == IDLE) begin
        csum    <= 8'd0;
        hdr_cnt <= 2'd0;
      end else if (rx_valid && ((state == HDR) || (state == DATA))) begin
        csum <= csum_next_c;
      end
      if ((state == HDR) && rx_valid) begin
        hdr_cnt <= hdr_cnt + 2'd1;
        hdr     <= {rx_byte, hdr[23:8]};
        if (hdr_cnt == 2'd3) begin
          wr_ptr     <= hdr_addr_c[ADDR_W-1:0];
          words_left <= hdr_len_c;
        end
      end
      if (load_c) begin
        wr_valid   <= 1'b1;
        wr_addr    <= wr_ptr;
        wr_data    <= word_c;
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        words_left <= words_left - 16'd1;
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
      end
      if (hold_set_c)      cpu_hold <= 1'b1;
      else if (done_set_c) cpu_hold <= 1'b0;
      busy       <= (state_d != IDLE);
      done_pulse <= done_set_c;
      err_pulse  <= err_set_c;
      if (err_set_c) err_code <= err_d_c;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader (ADDR_W=12, TIMEOUT_CYCLES=100).
`timescale 1ns/1ps
module tb_uart_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done_pulse;
  logic        err_pulse;
  logic [2:0]  err_code;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err  = 0;
  logic [63:0] wr_log[$];
  int d0, e0, w0;

  always #5 clk = ~clk;

  uart_prog_loader #(
    .ADDR_W        (12),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done_pulse(done_pulse),
    .err_pulse (err_pulse),
    .err_code  (err_code)
  );

  // Memory-side observer: records accepted writes and counts pulses.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) wr_log.push_back(64'({wr_addr, wr_data}));
    if (done_pulse) n_done++;
    if (err_pulse)  n_err++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Sends the low n bytes of v, most significant byte first.
  task automatic send_vec(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic snap();
    d0 = n_done;
    e0 = n_err;
    w0 = wr_log.size();
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    wr_ready = 1'b1;
    #23;
    check("rst_outs", 64'({wr_valid, wr_addr, wr_data, cpu_hold, busy, done_pulse, err_pulse, err_code}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Stray non-SYNC byte is ignored.
    send_byte(8'h5A);
    check("idle_ignore", 64'({busy, cpu_hold}), 64'd0);

    // Good packet; byte sum of 10 00 02 00 11..88 is 0x76, so 0x8A closes it.
    snap();
    send_byte(8'hA5);
    check("sync_hold", 64'({busy, cpu_hold}), 64'b11);
    send_vec({8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h8A}, 13);
    tick(4);
    check("good_nwr",  64'(wr_log.size() - w0), 64'd2);
    check("good_wr0",  wr_log[w0],     {32'h010, 32'h44332211});
    check("good_wr1",  wr_log[w0 + 1], {32'h011, 32'h88776655});
    check("good_done", 64'(n_done - d0), 64'd1);
    check("good_end",  64'({cpu_hold, busy, err_code}), 64'd0);

    // Same packet, checksum off by one.
    snap();
    send_vec({8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h8B}, 14);
    tick(4);
    check("bad_nwr",  64'(wr_log.size() - w0), 64'd2);
    check("bad_err",  64'(n_err - e0), 64'd1);
    check("bad_code", 64'(err_code), 64'd1);
    check("bad_hold", 64'({cpu_hold, busy, n_done - d0}), {1'b1, 1'b0, 32'd0});

    // Range error: 0xFFF + 2 > 4096.
    snap();
    send_vec({8'hA5, 8'hFF, 8'h0F, 8'h02, 8'h00}, 5);
    check("rng_code", 64'({err_code, busy, cpu_hold}), {3'd3, 1'b0, 1'b1});
    tick(3);
    check("rng_nwr", 64'(wr_log.size() - w0), 64'd0);

    // Boundary fit: 0xFFE + 2 == 4096; err_code stays sticky at 3.
    snap();
    send_vec({8'hA5, 8'hFE, 8'h0F, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h05, 8'h06, 8'h07, 8'h08, 8'hCD}, 14);
    tick(4);
    check("edge_nwr", 64'(wr_log.size() - w0), 64'd2);
    check("edge_wr0", wr_log[w0],     {32'hFFE, 32'h04030201});
    check("edge_wr1", wr_log[w0 + 1], {32'hFFF, 32'h08070605});
    check("edge_end", 64'({n_done - d0, cpu_hold, err_code}), {32'd1, 1'b0, 3'd3});

    // Zero-length packet at the last word: header sum 0x0E, checksum 0xF2.
    snap();
    send_vec({8'hA5, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'hF2}, 6);
    tick(4);
    check("zlen", 64'({n_done - d0, wr_log.size() - w0, cpu_hold}), {32'd1, 32'd0, 1'b0});

    // Overflow: memory stalls across two words.
    snap();
    wr_ready = 1'b0;
    send_vec({8'hA5, 8'h20, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 9);
    check("ovf_pend", 64'({wr_valid, wr_addr, wr_data}), {1'b1, 12'h020, 32'h44332211});
    send_vec({8'h55, 8'h66, 8'h77}, 3);
    check("ovf_noerr", 64'(n_err - e0), 64'd0);
    send_byte(8'h88);
    check("ovf_code", 64'({err_code, busy, cpu_hold}), {3'd2, 1'b0, 1'b1});
    check("ovf_keep", 64'({wr_valid, wr_addr, wr_data}), {1'b1, 12'h020, 32'h44332211});
    wr_ready = 1'b1;
    tick(4);
    check("ovf_nwr", 64'(wr_log.size() - w0), 64'd1);
    check("ovf_wr0", wr_log[w0], {32'h020, 32'h44332211});
    check("ovf_vld", 64'(wr_valid), 64'd0);

    // Stalled header.
    snap();
    send_vec({8'hA5, 8'h00, 8'h00}, 3);
    check("stall_busy", 64'(busy), 64'd1);
    tick(105);
`ifdef LOADER_TIMEOUT_EN
    check("tmo_code", 64'({err_code, busy, n_err - e0}), {3'd4, 1'b0, 32'd1});
`else
    check("notmo", 64'({err_code, busy, n_err - e0}), {3'd2, 1'b1, 32'd0});
`endif

    // Asynchronous reset in the middle of DATA.
    do_reset();
    wr_ready = 1'b0;
    send_vec({8'hA5, 8'h30, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 9);
    check("mid_pend", 64'({wr_valid, busy, cpu_hold}), 64'b111);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst", 64'({wr_valid, busy, cpu_hold, err_code}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    wr_ready = 1'b1;
    snap();
    send_vec({8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h8A}, 14);
    tick(4);
    check("post_nwr", 64'(wr_log.size() - w0), 64'd2);
    check("post_wr1", wr_log[w0 + 1], {32'h011, 32'h88776655});
    check("post_done", 64'({n_done - d0, cpu_hold, busy}), {32'd1, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
